// File: rtl/operand_entry_pkg.sv
// Shared constants and FSM encoding for the calculator operand entry front end.
package operand_entry_pkg;

  localparam int DIGITS  = 10;
  localparam int BCD_W   = 4;
  localparam int VAL_W   = DIGITS * BCD_W;
  localparam int COUNT_W = 4;

  localparam logic [COUNT_W-1:0] DIGITS_CNT = COUNT_W'(DIGITS);
  localparam logic [BCD_W-1:0]   MAX_DIGIT  = 4'd9;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_FULL   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/operand_entry_debounce.sv
// One pushbutton channel: 2-FF synchronizer, stability counter and a
// registered one-cycle pulse on each accepted press (release is silent).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      cnt_q       <= cnt_d;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/operand_entry.sv
// Debounced button front end building a BCD operand word and a one-cycle
// enter strobe for the calculator state controller.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               digit_raw,
  input  logic               bksp_raw,
  input  logic               clear_raw,
  input  logic               enter_raw,
  input  logic [BCD_W-1:0]   digit_sw,
  output logic [VAL_W-1:0]   o_val,
  output logic               o_enter,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_err
);

  logic [3:0] raw, press;
  assign raw = {enter_raw, clear_raw, bksp_raw, digit_raw};

  for (genvar g = 0; g < 4; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_btn (
      .clk_i  (i_clk),
      .rst_n_i(i_rst_n),
      .raw_i  (raw[g]),
      .press_o(press[g])
    );
  end

  logic digit_p, bksp_p, clear_p, enter_p;
  assign {enter_p, clear_p, bksp_p, digit_p} = press;

  state_e               state_q, state_d;
  logic [VAL_W-1:0]     val_q, val_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 enter_q, enter_d;
  logic                 full_q;

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    count_d = count_q;
    err_d   = err_q;
    enter_d = 1'b0;
    if (state_q == ST_COMMIT) begin
      // Commit lasts one cycle; any press landing now is dropped.
      state_d = ST_EMPTY;
      val_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (clear_p) begin
      state_d = ST_EMPTY;
      val_d   = '0;
      count_d = '0;
      err_d   = 1'b0;
    end else if (enter_p) begin
      state_d = ST_COMMIT;
      enter_d = 1'b1;
    end else if (bksp_p) begin
      if (count_q != '0) begin
        val_d   = val_q >> BCD_W;
        count_d = count_q - COUNT_W'(1);
        err_d   = 1'b0;
        state_d = (count_q == COUNT_W'(1)) ? ST_EMPTY : ST_ENTRY;
      end
    end else if (digit_p) begin
      if (digit_sw > MAX_DIGIT || state_q == ST_FULL) begin
        err_d = 1'b1;
      end else if (!(state_q == ST_EMPTY && digit_sw == '0)) begin
        val_d   = {val_q[VAL_W-BCD_W-1:0], digit_sw};
        count_d = count_q + COUNT_W'(1);
        err_d   = 1'b0;
        state_d = (count_q + COUNT_W'(1) == DIGITS_CNT) ? ST_FULL : ST_ENTRY;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      val_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      enter_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      count_q <= count_d;
      err_q   <= err_d;
      enter_q <= enter_d;
      full_q  <= (state_d == ST_FULL);
    end
  end

  assign o_val   = val_q;
  assign o_enter = enter_q;
  assign o_count = count_q;
  assign o_full  = full_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry with a short debounce window.
module tb_operand_entry;
  import operand_entry_pkg::*;

  localparam int DEB = 4;
  localparam int B_DIGIT = 0, B_BKSP = 1, B_CLEAR = 2, B_ENTER = 3;

  logic             clk = 1'b0;
  logic             clk_en = 1'b1;
  logic             rst_n = 1'b0;
  logic [3:0]       raw = '0;
  logic [3:0]       digit_sw = '0;
  logic [VAL_W-1:0] o_val;
  logic             o_enter;
  logic [3:0]       o_count;
  logic             o_full;
  logic             o_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [46:0] sb_q[$];

  operand_entry #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .digit_raw(raw[B_DIGIT]),
    .bksp_raw (raw[B_BKSP]),
    .clear_raw(raw[B_CLEAR]),
    .enter_raw(raw[B_ENTER]),
    .digit_sw (digit_sw),
    .o_val    (o_val),
    .o_enter  (o_enter),
    .o_count  (o_count),
    .o_full   (o_full),
    .o_err    (o_err)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [46:0] snap();
    return {o_val, o_count, o_full, o_err, o_enter};
  endfunction

  function automatic logic [46:0] mk(input logic [39:0] v, input logic [3:0] c,
                                     input logic f, input logic e, input logic en);
    return {v, c, f, e, en};
  endfunction

  // Raise a button before edge 1 and return just after edge DEB+4.
  task automatic press_start(input int b, input logic [3:0] sw);
    @(negedge clk);
    digit_sw = sw;
    raw[b]   = 1'b1;
    repeat (DEB + 4) @(posedge clk);
    #1;
  endtask

  task automatic release_all();
    @(negedge clk);
    raw = '0;
    repeat (DEB + 8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [46:0] exp;
    rst_n = 1'b0;
    #12;
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    exp = sb_q.pop_front();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h", snap(), exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_digits_enter();
    logic [46:0] exp;
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      v = {v[35:0], 4'(i + 1)};
      sb_q.push_back(mk(v, 4'(i + 1), 1'b0, 1'b0, 1'b0));
      press_start(B_DIGIT, 4'(i + 1));
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL digit_seq[%0d]: got %h expected %h", i, snap(), exp);
      end
      release_all();
    end
    sb_q.push_back(mk(40'h123, 4'd3, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    press_start(B_ENTER, 4'd0);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) begin
        @(posedge clk);
        #1;
      end
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL enter_cycle[%0d]: got %h expected %h", i, snap(), exp);
      end
    end
    release_all();
  endtask

  task automatic test_leading_zero_err();
    logic [46:0] exp;
    logic [3:0]  sws[6];
    logic [46:0] exps[6];
    int          btns[6];
    sws  = '{4'd0, 4'd0, 4'd5, 4'hA, 4'd7, 4'd0};
    btns = '{B_DIGIT, B_DIGIT, B_DIGIT, B_DIGIT, B_DIGIT, B_CLEAR};
    exps = '{mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0), mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0),
             mk(40'h5, 4'd1, 1'b0, 1'b0, 1'b0), mk(40'h5, 4'd1, 1'b0, 1'b1, 1'b0),
             mk(40'h57, 4'd2, 1'b0, 1'b0, 1'b0), mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0)};
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(exps[i]);
      press_start(btns[i], sws[i]);
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL lz_err[%0d]: got %h expected %h", i, snap(), exp);
      end
      release_all();
    end
  endtask

  task automatic test_full_bksp();
    logic [46:0] exp;
    logic [39:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      v = {v[35:0], 4'((i + 1) % 10)};
      sb_q.push_back(mk(v, 4'(i + 1), (i == 9), 1'b0, 1'b0));
      press_start(B_DIGIT, 4'((i + 1) % 10));
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL fill[%0d]: got %h expected %h", i, snap(), exp);
      end
      release_all();
    end
    sb_q.push_back(mk(40'h1234567890, 4'd10, 1'b1, 1'b1, 1'b0));
    sb_q.push_back(mk(40'h0123456789, 4'd9, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      press_start((i == 0) ? B_DIGIT : (i == 1) ? B_BKSP : B_CLEAR, 4'd7);
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL full_ops[%0d]: got %h expected %h", i, snap(), exp);
      end
      release_all();
    end
  endtask

  task automatic test_glitch();
    logic [46:0] exp;
    @(negedge clk);
    digit_sw = 4'd3;
    raw[B_DIGIT] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    raw[B_DIGIT] = 1'b0;
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    repeat (12) @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL glitch_short: got %h expected %h", snap(), exp);
    end
    @(negedge clk);
    raw[B_DIGIT] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    raw[B_DIGIT] = 1'b0;
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(40'h3, 4'd1, 1'b0, 1'b0, 1'b0));
    sb_q.push_back(mk(40'h3, 4'd1, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      repeat ((i == 0) ? 3 : (i == 1) ? 1 : 12) @(posedge clk);
      #1;
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL glitch_accept[%0d]: got %h expected %h", i, snap(), exp);
      end
    end
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    press_start(B_CLEAR, 4'd0);
    exp = sb_q.pop_front();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL glitch_clear: got %h expected %h", snap(), exp);
    end
    release_all();
  endtask

  task automatic test_clear_enter();
    logic [46:0] exp;
    logic        seen;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back((i == 0) ? mk(40'h4, 4'd1, 1'b0, 1'b0, 1'b0)
                              : mk(40'h42, 4'd2, 1'b0, 1'b0, 1'b0));
      press_start(B_DIGIT, (i == 0) ? 4'd4 : 4'd2);
      exp = sb_q.pop_front();
      n_tests++;
      if (snap() !== exp) begin
        n_fail++;
        $display("FAIL ce_setup[%0d]: got %h expected %h", i, snap(), exp);
      end
      release_all();
    end
    seen = 1'b0;
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    raw[B_CLEAR] = 1'b1;
    raw[B_ENTER] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (o_enter) seen = 1'b1;
      if (i == DEB + 4) begin
        exp = sb_q.pop_front();
        n_tests++;
        if (snap() !== exp) begin
          n_fail++;
          $display("FAIL clear_wins: got %h expected %h", snap(), exp);
        end
      end
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_suppressed: got o_enter seen=%0b expected 0", seen);
    end
    release_all();
  endtask

  task automatic test_async_reset();
    logic [46:0] exp;
    int          enters;
    sb_q.push_back(mk(40'h8, 4'd1, 1'b0, 1'b0, 1'b0));
    press_start(B_DIGIT, 4'd8);
    exp = sb_q.pop_front();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL ar_setup: got %h expected %h", snap(), exp);
    end
    release_all();
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    exp = sb_q.pop_front();
    n_tests++;
    if (snap() !== exp) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", snap(), exp);
    end
    raw[B_ENTER] = 1'b1;
    #5;
    rst_n = 1'b1;
    #5;
    clk_en = 1'b1;
    enters = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (o_enter) begin
        enters++;
        sb_q.push_back(mk(40'h0, 4'd0, 1'b0, 1'b0, 1'b1));
        exp = sb_q.pop_front();
        n_tests++;
        if (snap() !== exp) begin
          n_fail++;
          $display("FAIL held_enter_val: got %h expected %h", snap(), exp);
        end
      end
    end
    n_tests++;
    if (enters !== 1) begin
      n_fail++;
      $display("FAIL held_enter_count: got %0d pulses expected 1", enters);
    end
    release_all();
  endtask

  initial begin
    test_reset();
    test_digits_enter();
    test_leading_zero_err();
    test_full_bksp();
    test_glitch();
    test_clear_enter();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
